idelay_scan_ctrl: RTL and testbench

Automatic eye-scan controller for the serial receive path (IDELAYE3 + 1:8 ISERDESE3 pair and its delay controller). On `start` it sweeps the P-side delay tap across its range and measures `bit_align_errors` over a fixed dwell at each step. It then finds the widest contiguous error-free window and programs the tap at the window centre. It sits between slow control and the receive block's `delay_set`/`delay_in`/`delay_ready`/`reset_counters` handshake.

---
 rtl/idelay_scan_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_idelay_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_scan_ctrl.sv
// Eye-scan controller: sweeps the IDELAY tap, dwells on the error counter at each point, then programs the centre of the widest clean window.
// Optional IDELAY_SCAN_STATUS_EN adds cur_tap/last_errors status outputs.
module idelay_scan_ctrl #(
  parameter int TAP_STEP    = 8,
  parameter int TAP_MAX     = 504,
  parameter int DWELL       = 1024,
  parameter int ERR_THRESH  = 0,
  parameter int RDY_TIMEOUT = 4096
) (
  input  logic        clk160,
  input  logic        rstb,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        scan_fail,
  output logic [8:0]  result_delay,
  output logic [8:0]  eye_width,
  output logic [8:0]  delay_in,
  output logic        delay_set,
  input  logic        delay_ready,
  output logic        reset_counters,
  input  logic [15:0] bit_align_errors
`ifdef IDELAY_SCAN_STATUS_EN
  ,
  output logic [8:0]  cur_tap,
  output logic [15:0] last_errors
`endif
);

  localparam int DW = $clog2(DWELL);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);
  localparam logic [9:0] STEP10 = 10'(TAP_STEP);
  localparam logic [9:0] MAX10  = 10'(TAP_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_WAIT_RDY, S_CLEAR, S_DWELL, S_EVAL, S_FINAL_SET, S_FINAL_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    tap_q, tap_d;
  logic [9:0]    run_start_q, run_start_d;
  logic [6:0]    run_len_q, run_len_d;
  logic [9:0]    best_start_q, best_start_d;
  logic [6:0]    best_len_q, best_len_d;
  logic          tmo_hit_q, tmo_hit_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          busy_d, done_d, scan_fail_d, delay_set_d, reset_counters_d;
  logic [8:0]    result_delay_d, eye_width_d, delay_in_d;

  logic          good, last_pt;
  logic [6:0]    eff_len;
  logic [9:0]    eff_start;
  logic [15:0]   tgt_wide, width_wide;

  function automatic logic [8:0] clamp9(input logic [15:0] v);
    return (v > 16'd511) ? 9'd511 : v[8:0];
  endfunction

  always_ff @(posedge clk160) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      tap_q          <= '0;
      run_start_q    <= '0;
      run_len_q      <= '0;
      best_start_q   <= '0;
      best_len_q     <= '0;
      tmo_hit_q      <= 1'b0;
      dwell_q        <= '0;
      tmo_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      scan_fail      <= 1'b0;
      result_delay   <= '0;
      eye_width      <= '0;
      delay_in       <= '0;
      delay_set      <= 1'b0;
      reset_counters <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      run_start_q    <= run_start_d;
      run_len_q      <= run_len_d;
      best_start_q   <= best_start_d;
      best_len_q     <= best_len_d;
      tmo_hit_q      <= tmo_hit_d;
      dwell_q        <= dwell_d;
      tmo_q          <= tmo_d;
      busy           <= busy_d;
      done           <= done_d;
      scan_fail      <= scan_fail_d;
      result_delay   <= result_delay_d;
      eye_width      <= eye_width_d;
      delay_in       <= delay_in_d;
      delay_set      <= delay_set_d;
      reset_counters <= reset_counters_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tap_d            = tap_q;
    run_start_d      = run_start_q;
    run_len_d        = run_len_q;
    best_start_d     = best_start_q;
    best_len_d       = best_len_q;
    tmo_hit_d        = tmo_hit_q;
    dwell_d          = dwell_q;
    tmo_d            = tmo_q;
    busy_d           = busy;
    done_d           = done;
    scan_fail_d      = scan_fail;
    result_delay_d   = result_delay;
    eye_width_d      = eye_width;
    delay_in_d       = delay_in;
    delay_set_d      = 1'b0;
    reset_counters_d = 1'b0;

    good       = (bit_align_errors <= 16'(ERR_THRESH));
    last_pt    = (tap_q + STEP10) > MAX10;
    eff_len    = good ? (run_len_q + 7'd1) : run_len_q;
    eff_start  = (good && (run_len_q == 7'd0)) ? tap_q : run_start_q;
    tgt_wide   = 16'(best_start_q) + 16'((best_len_q - 7'd1) >> 1) * 16'(TAP_STEP);
    width_wide = 16'(best_len_q) * 16'(TAP_STEP);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          tmo_hit_d    = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          scan_fail_d  = 1'b0;
          state_d      = S_SET;
        end
      end
      S_SET: begin
        delay_in_d  = clamp9(16'(tap_q));
        delay_set_d = 1'b1;
        tmo_d       = '0;
        state_d     = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // ready is stale while the strobe is still on the wire
        if (delay_ready && !delay_set) begin
          reset_counters_d = 1'b1;
          state_d          = S_CLEAR;
        end else if (tmo_q >= TW'(RDY_TIMEOUT - 1)) begin
          scan_fail_d = 1'b1;
          tmo_hit_d   = 1'b1;
          state_d     = S_FINAL_SET;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CLEAR: begin
        dwell_d = DW'(DWELL - 1);
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (dwell_q == '0) state_d = S_EVAL;
        else               dwell_d = dwell_q - 1'b1;
      end
      S_EVAL: begin
        if (!good || last_pt) begin
          // strict compare keeps the earlier window on ties
          if (eff_len > best_len_q) begin
            best_start_d = eff_start;
            best_len_d   = eff_len;
          end
          run_len_d = '0;
        end else begin
          run_start_d = eff_start;
          run_len_d   = eff_len;
        end
        if (last_pt) begin
          state_d = S_FINAL_SET;
        end else begin
          tap_d   = tap_q + STEP10;
          state_d = S_SET;
        end
      end
      S_FINAL_SET: begin
        if (best_len_q == 7'd0) scan_fail_d = 1'b1;
        delay_in_d  = (tmo_hit_q || (best_len_q == 7'd0)) ? 9'd0 : clamp9(tgt_wide);
        delay_set_d = 1'b1;
        state_d     = S_FINAL_WAIT;
      end
      S_FINAL_WAIT: begin
        if (delay_ready && !delay_set) begin
          result_delay_d = delay_in;
          eye_width_d    = clamp9(width_wide);
          done_d         = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IDELAY_SCAN_STATUS_EN
  always_ff @(posedge clk160) begin
    if (!rstb) begin
      cur_tap     <= '0;
      last_errors <= '0;
    end else if (state_q == S_EVAL) begin
      cur_tap     <= clamp9(16'(tap_q));
      last_errors <= bit_align_errors;
    end
  end
`endif

endmodule

// File: tb/tb_idelay_scan_ctrl.sv
// Bench for idelay_scan_ctrl: table of eye shapes plus reset/timeout/restart sequences.
module tb_idelay_scan_ctrl;

  localparam int TAP_STEP    = 8;
  localparam int TAP_MAX     = 504;
  localparam int DWELL       = 16;
  localparam int ERR_THRESH  = 2;
  localparam int RDY_TIMEOUT = 64;
  localparam int NV          = 8;

  logic        clk160, rstb, start;
  logic        busy, done, scan_fail, delay_set, delay_ready, reset_counters;
  logic [8:0]  result_delay, eye_width, delay_in;
  logic [15:0] bit_align_errors;
`ifdef IDELAY_SCAN_STATUS_EN
  logic [8:0]  cur_tap;
  logic [15:0] last_errors;
`endif

  typedef struct { int lo1; int hi1; int lo2; int hi2; bit tmo; int res; int w; bit fail; } vec_t;
  typedef struct { int res; int w; bit fail; } exp_t;

  vec_t vecs [NV];
  exp_t exp_q[$];
  int   exp_dly_q[$];
  int   errors = 0;
  int   checks = 0;
  int   w_lo1 = 511, w_hi1 = 0, w_lo2 = 511, w_hi2 = 0;
  bit   block_rdy = 1'b0;
  int   rdy_cnt = 0;
  int   cur_delay = 0;

  idelay_scan_ctrl #(
    .TAP_STEP(TAP_STEP), .TAP_MAX(TAP_MAX), .DWELL(DWELL),
    .ERR_THRESH(ERR_THRESH), .RDY_TIMEOUT(RDY_TIMEOUT)
  ) dut (
    .clk160(clk160), .rstb(rstb), .start(start), .busy(busy), .done(done),
    .scan_fail(scan_fail), .result_delay(result_delay), .eye_width(eye_width),
    .delay_in(delay_in), .delay_set(delay_set), .delay_ready(delay_ready),
    .reset_counters(reset_counters), .bit_align_errors(bit_align_errors)
`ifdef IDELAY_SCAN_STATUS_EN
    , .cur_tap(cur_tap), .last_errors(last_errors)
`endif
  );

  initial begin
    clk160 = 1'b0;
    forever #5 clk160 = ~clk160;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_win(input int d);
    return ((d >= w_lo1) && (d <= w_hi1)) || ((d >= w_lo2) && (d <= w_hi2));
  endfunction

  // Receive-block model: ready drops on delay_set and returns two cycles later;
  // error count follows the tap last applied. Also scores every delay_set.
  initial begin
    int e;
    delay_ready = 1'b1;
    bit_align_errors = 16'd0;
    forever begin
      @(posedge clk160); #1;
      if (delay_set) begin
        cur_delay = int'(delay_in);
        rdy_cnt = 2;
        if (exp_dly_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delay_set: got delay_in=%0d expected no strobe", delay_in);
        end else begin
          e = exp_dly_q.pop_front();
          check("delay_in", 32'(delay_in), e);
        end
      end else if (rdy_cnt != 0) begin
        rdy_cnt--;
      end
      delay_ready = (rdy_cnt == 0) && !block_rdy;
      bit_align_errors = in_win(cur_delay) ? 16'(ERR_THRESH) : 16'(ERR_THRESH + 1);
    end
  end

  task automatic push_dly(input bit tmo, input int res);
    if (tmo) begin
      exp_dly_q.push_back(0);
      exp_dly_q.push_back(0);
    end else begin
      for (int t = 0; t <= TAP_MAX; t += TAP_STEP) exp_dly_q.push_back(t);
      exp_dly_q.push_back(res);
    end
  endtask

  task automatic wait_and_score();
    bit   got = 1'b0;
    exp_t e;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk160);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 1);
    e = exp_q.pop_front();
    if (got) begin
      check("result_delay", 32'(result_delay), e.res);
      check("eye_width", 32'(eye_width), e.w);
      check("scan_fail", 32'(scan_fail), 32'(e.fail));
      check("busy_at_done", 32'(busy), 0);
      check("all_sets_seen", exp_dly_q.size(), 0);
    end
  endtask

  task automatic run_scan(input vec_t v);
    exp_t e;
    w_lo1 = v.lo1; w_hi1 = v.hi1; w_lo2 = v.lo2; w_hi2 = v.hi2;
    block_rdy = v.tmo;
    push_dly(v.tmo, v.res);
    e.res = v.res; e.w = v.w; e.fail = v.fail;
    exp_q.push_back(e);
    @(negedge clk160) start = 1'b1;
    @(negedge clk160) start = 1'b0;
    if (v.tmo) begin
      repeat (100) @(negedge clk160);
      check("tmo_still_busy", 32'(busy), 1);
      check("tmo_not_done", 32'(done), 0);
      block_rdy = 1'b0;
    end
    wait_and_score();
    repeat (3) @(negedge clk160);
  endtask

  initial begin
    int   n;
    exp_t e;
    vecs[0] = '{96, 200, 511, 0, 1'b0, 144, 112, 1'b0};
    vecs[1] = '{40, 72, 296, 328, 1'b0, 56, 40, 1'b0};
    vecs[2] = '{511, 0, 511, 0, 1'b0, 0, 0, 1'b1};
    vecs[3] = '{0, 511, 511, 0, 1'b0, 248, 511, 1'b0};
    vecs[4] = '{8, 16, 400, 448, 1'b0, 424, 56, 1'b0};
    vecs[5] = '{504, 504, 511, 0, 1'b0, 504, 8, 1'b0};
    vecs[6] = '{0, 0, 511, 0, 1'b0, 0, 8, 1'b0};
    vecs[7] = '{96, 200, 511, 0, 1'b1, 0, 0, 1'b1};

    rstb = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk160);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_scan_fail", 32'(scan_fail), 0);
    check("rst_result_delay", 32'(result_delay), 0);
    check("rst_eye_width", 32'(eye_width), 0);
    check("rst_delay_in", 32'(delay_in), 0);
    check("rst_delay_set", 32'(delay_set), 0);
    check("rst_reset_counters", 32'(reset_counters), 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk160);

    for (int i = 0; i < NV; i++) run_scan(vecs[i]);

    // Reset during the dwell of the tap-96 point aborts everything.
    w_lo1 = 96; w_hi1 = 200; w_lo2 = 511; w_hi2 = 0;
    push_dly(1'b0, 144);
    @(negedge clk160) start = 1'b1;
    @(negedge clk160) start = 1'b0;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      if (reset_counters) n++;
      if (n == 13) break;
      @(negedge clk160);
    end
    check("reach_tap96", n, 13);
    repeat (5) @(negedge clk160);
    check("pre_rst_delay_in", 32'(delay_in), 96);
    rstb = 1'b0;
    @(negedge clk160);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_scan_fail", 32'(scan_fail), 0);
    check("mid_rst_result_delay", 32'(result_delay), 0);
    check("mid_rst_eye_width", 32'(eye_width), 0);
    check("mid_rst_delay_in", 32'(delay_in), 0);
    check("mid_rst_delay_set", 32'(delay_set), 0);
    check("mid_rst_reset_counters", 32'(reset_counters), 0);
    rstb = 1'b1;
    exp_dly_q.delete();
    repeat (30) @(negedge clk160);
    check("post_rst_idle_busy", 32'(busy), 0);
    check("post_rst_idle_done", 32'(done), 0);

    // Fresh scan with start-edge timing and an ignored start while busy.
    w_lo1 = 40; w_hi1 = 72; w_lo2 = 296; w_hi2 = 328;
    push_dly(1'b0, 56);
    e.res = 56; e.w = 40; e.fail = 1'b0;
    exp_q.push_back(e);
    @(negedge clk160) start = 1'b1;
    @(negedge clk160) start = 1'b0;
    check("busy_rise", 32'(busy), 1);
    check("set_not_yet", 32'(delay_set), 0);
    @(negedge clk160);
    check("set_pulse", 32'(delay_set), 1);
    @(negedge clk160);
    check("set_one_cycle", 32'(delay_set), 0);
    repeat (200) @(negedge clk160);
    start = 1'b1;
    @(negedge clk160) start = 1'b0;
    check("busy_after_ignored_start", 32'(busy), 1);
    wait_and_score();
    repeat (10) @(negedge clk160);
    check("done_held", 32'(done), 1);
    check("result_held", 32'(result_delay), 56);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
